ft245_sync_ctrl: RTL and testbench

- Parametrised successor to the team's synchronous FT245 bridge. Moves bytes between an FTDI chip in sync-FIFO mode and an on-chip TX FIFO (read side) and RX FIFO (write side).
- Adds the following:
  - configurable bus width and OE turnaround;
  - bounded, fair read/write bursts;
  - correct per-beat handshake qualification;
  - byte counters.
- The tristate pad stays outside this block; it exposes split in/out/oe data ports.

---
 rtl/ft245_pkg.sv | 23 ++
 rtl/ft245_burst_arb.sv | 58 +++++
 rtl/ft245_sync_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ft245_sync_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared types and default parameter values for the synchronous FT245 controller.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_OE = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  localparam int DEF_DW        = 8;
  localparam int DEF_OE_WAIT   = 1;
  localparam int DEF_MAX_BURST = 64;
  localparam int DEF_CNT_W     = 32;
  localparam int DEF_SIWU_IDLE = 8;

endpackage

// File: rtl/ft245_burst_arb.sv
// Direction arbiter for the FT245 controller: alternates direction under contention
// and bounds each burst to MAX_BURST beats while the other direction is waiting.
module ft245_burst_arb
  import ft245_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rd_req,
  input  logic   wr_req,
  input  logic   rd_beat,
  input  logic   wr_beat,
  input  state_t phase,
  output dir_t   grant,
  output logic   burst_done
);

  localparam int BW = $clog2(MAX_BURST + 1) + 1;

  logic [BW-1:0] burst_cnt;
  dir_t          last_dir;
  logic          beat;
  logic          active;

  assign beat   = rd_beat | wr_beat;
  assign active = (phase == ST_RD) || (phase == ST_WR);

  // last_dir follows the running burst; it is only consulted in IDLE,
  // so it always holds the direction of the burst that just ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      last_dir  <= DIR_READ;
    end else begin
      if (!active)
        burst_cnt <= '0;
      else if (beat && int'(burst_cnt) < MAX_BURST)
        burst_cnt <= burst_cnt + BW'(1);
      if (phase == ST_RD)
        last_dir <= DIR_READ;
      else if (phase == ST_WR)
        last_dir <= DIR_WRITE;
    end
  end

  // Counting the beat in flight lets the FSM leave on the edge of the last allowed beat.
  always_comb begin
    burst_done = (MAX_BURST != 0) && ((int'(burst_cnt) + int'(beat)) >= MAX_BURST);
    if (rd_req && wr_req)
      grant = (last_dir == DIR_READ) ? DIR_WRITE : DIR_READ;
    else if (wr_req)
      grant = DIR_WRITE;
    else
      grant = DIR_READ;
  end

endmodule

// File: rtl/ft245_sync_ctrl.sv
// FT245 sync-FIFO bridge: FT bus <-> on-chip TX/RX FIFOs with fair bounded bursts.
// Optional macro FT245_SIWU_EN adds a send-immediate (SIWU) pulse after TX idles.
module ft245_sync_ctrl
  import ft245_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int OE_WAIT   = DEF_OE_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SIWU_IDLE = DEF_SIWU_IDLE
) (
  input  logic             ft_clkout,
  input  logic             rst,
  input  logic [DW-1:0]    ft_data_in,
  output logic [DW-1:0]    ft_data_out,
  output logic             ft_data_oe,
  input  logic             ft_rxf_n,
  input  logic             ft_txe_n,
  output logic             ft_rd_n,
  output logic             ft_wr_n,
  output logic             ft_oe_n,
  output logic             ft_siwu_n,
  input  logic [DW-1:0]    tx_rdata,
  input  logic             tx_rempty,
  output logic             tx_rinc,
  output logic [DW-1:0]    rx_wdata,
  input  logic             rx_wfull,
  output logic             rx_winc,
  output logic [CNT_W-1:0] rx_beats,
  output logic [CNT_W-1:0] tx_beats,
  output logic [2:0]       state_out
);

  if (!(DW == 8 || DW == 16)) begin : g_bad_dw
    $error("ft245_sync_ctrl: DW must be 8 or 16");
  end
  if (OE_WAIT < 1 || OE_WAIT > 3) begin : g_bad_oe_wait
    $error("ft245_sync_ctrl: OE_WAIT must be 1..3");
  end
  if (SIWU_IDLE < 1) begin : g_bad_siwu_idle
    $error("ft245_sync_ctrl: SIWU_IDLE must be at least 1");
  end

  localparam logic [1:0] OE_LAST = 2'(OE_WAIT - 1);

  state_t     state, state_nxt;
  logic [1:0] oe_cnt;
  logic       rd_req, wr_req;
  logic       rd_beat, wr_beat;
  dir_t       grant;
  logic       burst_done;

  assign rd_req  = !ft_rxf_n && !rx_wfull;
  assign wr_req  = !ft_txe_n && !tx_rempty;
  // Beat qualifiers written in terms of state, which is exactly when the strobe is low.
  assign rd_beat = (state == ST_RD) && !ft_rxf_n && !rx_wfull;
  assign wr_beat = (state == ST_WR) && !tx_rempty && !ft_txe_n;

  assign rx_winc     = rd_beat;
  assign rx_wdata    = ft_data_in;
  assign tx_rinc     = wr_beat;
  assign ft_data_out = tx_rdata;
  assign state_out   = state;

  ft245_burst_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk        (ft_clkout),
    .rst        (rst),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .rd_beat    (rd_beat),
    .wr_beat    (wr_beat),
    .phase      (state),
    .grant      (grant),
    .burst_done (burst_done)
  );

  always_ff @(posedge ft_clkout) begin
    if (rst) begin
      state    <= ST_IDLE;
      oe_cnt   <= '0;
      rx_beats <= '0;
      tx_beats <= '0;
    end else begin
      state    <= state_nxt;
      oe_cnt   <= (state == ST_RD_OE) ? oe_cnt + 2'd1 : 2'd0;
      if (rd_beat)
        rx_beats <= rx_beats + CNT_W'(1);
      if (wr_beat)
        tx_beats <= tx_beats + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    ft_oe_n    = 1'b1;
    ft_rd_n    = 1'b1;
    ft_wr_n    = 1'b1;
    ft_data_oe = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req || wr_req)
          state_nxt = (grant == DIR_WRITE) ? ST_WR : ST_RD_OE;
      end
      ST_RD_OE: begin
        ft_oe_n = 1'b0;
        if (!rd_req)
          state_nxt = ST_TURN;
        else if (oe_cnt == OE_LAST)
          state_nxt = ST_RD;
      end
      ST_RD: begin
        ft_oe_n = 1'b0;
        ft_rd_n = 1'b0;
        if (!rd_req || (burst_done && wr_req))
          state_nxt = ST_TURN;
      end
      ST_WR: begin
        ft_data_oe = 1'b1;
        ft_wr_n    = tx_rempty;
        if (!wr_req || (burst_done && rd_req))
          state_nxt = ST_IDLE;
      end
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef FT245_SIWU_EN
  localparam int SW = $clog2(SIWU_IDLE + 1);

  logic          siwu_armed;
  logic [SW-1:0] idle_cnt;
  logic          idle_ok;
  logic          siwu_fire;

  assign idle_ok   = (state == ST_IDLE) && tx_rempty;
  assign siwu_fire = siwu_armed && idle_ok && (int'(idle_cnt) == SIWU_IDLE);
  assign ft_siwu_n = !siwu_fire;

  // Armed when a write burst drains the TX FIFO; any later write beat cancels it.
  always_ff @(posedge ft_clkout) begin
    if (rst) begin
      siwu_armed <= 1'b0;
      idle_cnt   <= '0;
    end else if (wr_beat) begin
      siwu_armed <= 1'b0;
      idle_cnt   <= '0;
    end else if (state == ST_WR && state_nxt != ST_WR && tx_rempty) begin
      siwu_armed <= 1'b1;
      idle_cnt   <= '0;
    end else if (siwu_fire) begin
      siwu_armed <= 1'b0;
    end else if (siwu_armed) begin
      idle_cnt <= idle_ok ? idle_cnt + SW'(1) : '0;
    end
  end
`else
  assign ft_siwu_n = 1'b1;
`endif

endmodule

// File: tb/tb_ft245_sync_ctrl.sv
// Scoreboard bench for ft245_sync_ctrl: FT source, TX FIFO and RX sink models with
// expected-data queues checked on every completed beat.
module tb_ft245_sync_ctrl;

  localparam int DW        = 8;
  localparam int OE_WAIT   = 1;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 32;
  localparam int SIWU_IDLE = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    ft_data_in = '0;
  logic [DW-1:0]    ft_data_out;
  logic             ft_data_oe;
  logic             ft_rxf_n = 1'b1;
  logic             ft_txe_n = 1'b1;
  logic             ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n;
  logic [DW-1:0]    tx_rdata = '0;
  logic             tx_rempty = 1'b1;
  logic             tx_rinc;
  logic [DW-1:0]    rx_wdata;
  logic             rx_wfull = 1'b0;
  logic             rx_winc;
  logic [CNT_W-1:0] rx_beats, tx_beats;
  logic [2:0]       state_out;

  always #5 clk = ~clk;

  ft245_sync_ctrl #(
    .DW        (DW),
    .OE_WAIT   (OE_WAIT),
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W),
    .SIWU_IDLE (SIWU_IDLE)
  ) dut (
    .ft_clkout   (clk),
    .rst         (rst),
    .ft_data_in  (ft_data_in),
    .ft_data_out (ft_data_out),
    .ft_data_oe  (ft_data_oe),
    .ft_rxf_n    (ft_rxf_n),
    .ft_txe_n    (ft_txe_n),
    .ft_rd_n     (ft_rd_n),
    .ft_wr_n     (ft_wr_n),
    .ft_oe_n     (ft_oe_n),
    .ft_siwu_n   (ft_siwu_n),
    .tx_rdata    (tx_rdata),
    .tx_rempty   (tx_rempty),
    .tx_rinc     (tx_rinc),
    .rx_wdata    (rx_wdata),
    .rx_wfull    (rx_wfull),
    .rx_winc     (rx_winc),
    .rx_beats    (rx_beats),
    .tx_beats    (tx_beats),
    .state_out   (state_out)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] txf_q[$];
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_tx[$];
  bit            beat_log[$];

  int rx_pop_req = 0, tx_pop_req = 0, rx_pop_done = 0, tx_pop_done = 0;
  int cyc = 0, rx_pulses = 0, tx_pulses = 0;
  int bus_viol = 0, rd_exit_viol = 0, siwu_lows = 0, siwu_cyc = -1;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO / FT models: consume completed beats and present the next word just after the edge.
  always begin
    logic [DW-1:0] dummy;
    @(posedge clk);
    #1;
    cyc++;
    while (rx_pop_done < rx_pop_req) begin
      if (src_q.size() != 0) dummy = src_q.pop_front();
      rx_pop_done++;
    end
    while (tx_pop_done < tx_pop_req) begin
      if (txf_q.size() != 0) dummy = txf_q.pop_front();
      tx_pop_done++;
    end
    ft_rxf_n   = (src_q.size() == 0);
    ft_data_in = (src_q.size() != 0) ? src_q[0] : '0;
    tx_rempty  = (txf_q.size() == 0);
    tx_rdata   = (txf_q.size() != 0) ? txf_q[0] : '0;
  end

  // Monitor on the falling edge: scoreboard compare for every qualified beat.
  always @(negedge clk) begin
    if (ft_data_oe && !ft_oe_n) bus_viol++;
    if (prev_state == 3'd2 && state_out != 3'd2 && state_out != 3'd4) rd_exit_viol++;
    prev_state = state_out;
    if (rx_winc) begin
      rx_pulses++;
      beat_log.push_back(1'b0);
      chk("rx_sb_nonempty", exp_rx.size() != 0, 1);
      if (exp_rx.size() != 0) chk("rx_data", rx_wdata, exp_rx.pop_front());
      rx_pop_req++;
    end
    if (tx_rinc) begin
      tx_pulses++;
      beat_log.push_back(1'b1);
      chk("tx_sb_nonempty", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) chk("tx_data", ft_data_out, exp_tx.pop_front());
      tx_pop_req++;
    end
    if (!ft_siwu_n) begin
      siwu_lows++;
      siwu_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1, "bench stopped by watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_rx(input logic [DW-1:0] b);
    src_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic push_tx(input logic [DW-1:0] w);
    txf_q.push_back(w);
    exp_tx.push_back(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input bit is_rx, input int target, input int lim);
    int n = 0;
    while (((is_rx ? rx_beats : tx_beats) != CNT_W'(target)) && n < lim) begin
      tick();
      n++;
    end
    chk(tag, is_rx ? rx_beats : tx_beats, target);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (state_out != 3'd0 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, state_out, 0);
  endtask

  initial begin
    logic [2:0] st_tr [25];
    bit         oe_tr [25];
    bit         rd_tr [25];
    int         first_oe, first_rd, last_rd, p0, bl0, s0, t_idle;
    int         run_len[$];
    bit         run_dir[$];

    tick();
    tick();
    chk("rst_state", state_out, 0);
    chk("rst_rd_n", ft_rd_n, 1);
    chk("rst_wr_n", ft_wr_n, 1);
    chk("rst_oe_n", ft_oe_n, 1);
    chk("rst_data_oe", ft_data_oe, 0);
    chk("rst_tx_rinc", tx_rinc, 0);
    chk("rst_rx_winc", rx_winc, 0);
    chk("rst_rx_beats", rx_beats, 0);
    chk("rst_tx_beats", tx_beats, 0);
    chk("rst_siwu_n", ft_siwu_n, 1);
    rst = 1'b0;
    tick();

    // Five-byte read burst
    p0 = rx_pulses;
    for (int b = 0; b < 5; b++) push_rx(8'h11 + 8'(b));
    for (int i = 0; i < 25; i++) begin
      tick();
      st_tr[i] = state_out;
      oe_tr[i] = ft_oe_n;
      rd_tr[i] = ft_rd_n;
    end
    first_oe = -1;
    first_rd = -1;
    last_rd  = 0;
    for (int i = 0; i < 25; i++) begin
      if (!oe_tr[i] && first_oe < 0) first_oe = i;
      if (!rd_tr[i] && first_rd < 0) first_rd = i;
      if (st_tr[i] == 3'd2) last_rd = i;
    end
    if (last_rd > 22) last_rd = 22;
    chk("t1_oe_lead", first_rd - first_oe, OE_WAIT);
    chk("t1_winc_cycles", rx_pulses - p0, 5);
    chk("t1_rx_beats", rx_beats, 5);
    chk("t1_turn_after_rd", st_tr[last_rd + 1], 4);
    chk("t1_idle_after_turn", st_tr[last_rd + 2], 0);
    chk("t1_sb_empty", exp_rx.size(), 0);

    // Three-word write with ft_txe_n high for two cycles mid-burst
    p0 = tx_pulses;
    push_tx(8'hA1);
    push_tx(8'hA2);
    push_tx(8'hA3);
    ft_txe_n = 1'b0;
    wait_cnt("t2_first_beat", 1'b0, 1, 20);
    ft_txe_n = 1'b1;
    tick();
    tick();
    ft_txe_n = 1'b0;
    wait_cnt("t2_tx_beats", 1'b0, 3, 20);
    wait_idle("t2_idle", 10);
    chk("t2_rinc_pulses", tx_pulses - p0, 3);
    chk("t2_sb_empty", exp_tx.size(), 0);

    // Both directions pending: bursts of MAX_BURST alternate
    bl0 = beat_log.size();
    for (int k = 0; k < 12; k++) begin
      push_rx(8'h30 + 8'(k));
      push_tx(8'hC0 + 8'(k));
    end
    wait_cnt("t3_rx_total", 1'b1, 17, 200);
    wait_cnt("t3_tx_total", 1'b0, 15, 200);
    wait_idle("t3_idle", 10);
    for (int i = bl0; i < beat_log.size(); i++) begin
      if (i == bl0 || beat_log[i] != beat_log[i-1]) begin
        run_len.push_back(1);
        run_dir.push_back(beat_log[i]);
      end else begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
      end
    end
    chk("t3_runs", run_len.size(), 6);
    for (int k = 0; k < run_len.size() && k < 6; k++) begin
      chk("t3_run_len", run_len[k], MAX_BURST);
      chk("t3_run_dir", run_dir[k], k % 2);
    end
    chk("t3_rx_sb_empty", exp_rx.size(), 0);
    chk("t3_tx_sb_empty", exp_tx.size(), 0);

    // RX FIFO fills on the third read beat
    do_reset();
    chk("t4_cnt_clear", rx_beats, 0);
    for (int b = 0; b < 5; b++) push_rx(8'h51 + 8'(b));
    wait_cnt("t4_two_beats", 1'b1, 2, 30);
    rx_wfull = 1'b1;
    #1;
    chk("t4_winc_blocked", rx_winc, 0);
    chk("t4_state_rd", state_out, 2);
    tick();
    chk("t4_turn", state_out, 4);
    tick();
    chk("t4_idle", state_out, 0);
    chk("t4_rx_beats", rx_beats, 2);
    tick();
    tick();
    chk("t4_hold_idle", state_out, 0);
    rx_wfull = 1'b0;
    wait_cnt("t4_drain", 1'b1, 5, 30);
    wait_idle("t4_idle_end", 10);
    chk("t4_sb_empty", exp_rx.size(), 0);

    // Reset in the middle of a write burst
    for (int k = 0; k < 6; k++) push_tx(8'hE0 + 8'(k));
    wait_cnt("t5_two_beats", 1'b0, 2, 30);
    rst = 1'b1;
    tick();
    chk("t5_rd_n", ft_rd_n, 1);
    chk("t5_wr_n", ft_wr_n, 1);
    chk("t5_oe_n", ft_oe_n, 1);
    chk("t5_data_oe", ft_data_oe, 0);
    chk("t5_tx_rinc", tx_rinc, 0);
    chk("t5_state", state_out, 0);
    chk("t5_rx_beats", rx_beats, 0);
    chk("t5_tx_beats", tx_beats, 0);
    rst = 1'b0;
    wait_cnt("t5_resume", 1'b0, 3, 30);
    wait_idle("t5_idle", 10);
    chk("t5_sb_empty", exp_tx.size(), 0);

    // Single write, then TX FIFO stays empty
    s0 = siwu_lows;
    push_tx(8'h77);
    wait_cnt("t6_beat", 1'b0, 4, 20);
    wait_idle("t6_idle", 10);
    t_idle = cyc;
    repeat (20) tick();
`ifdef FT245_SIWU_EN
    chk("t6_siwu_pulses", siwu_lows - s0, 1);
    chk("t6_siwu_delay", siwu_cyc - t_idle, SIWU_IDLE);
`else
    chk("t6_siwu_pulses", siwu_lows - s0, 0);
    chk("siwu_never_low", siwu_lows, 0);
`endif
    chk("t6_siwu_level", ft_siwu_n, 1);

    chk("bus_ownership", bus_viol, 0);
    chk("rd_exit_via_turn", rd_exit_viol, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
